// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter made of WIDTH JK-style stages.
// Each stage gets an explicit J/K pair: 10/01 on load, 11/00 (toggle/hold) when counting.
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic             at_max;
  logic             at_zero;
  logic             din_ok;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_next;
  logic             wrap_d;
  logic             err_d;

  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);
  // Extra MSB so the range check also works when MOD == 2**WIDTH.
  assign din_ok  = ({1'b0, din} < MOD_EXT);

  always_comb begin
    target = q;
    j      = '0;
    k      = '0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      target = din_ok ? din : '0;
      err_d  = ~din_ok;
      j      = target;
      k      = ~target;
    end else if (en) begin
      if (up) begin
        target = at_max ? '0 : q + ONE;
        wrap_d = at_max;
      end else begin
        target = at_zero ? MAX : q - ONE;
        wrap_d = at_zero;
      end
      j = q ^ target;
      k = q ^ target;
    end
    // JK characteristic equation applied per bit
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_next;
      wrap     <= wrap_d;
      load_err <= err_d;
    end
  end

  assign qb = ~q;
  assign tc = en & (up ? at_max : at_zero);

endmodule
